// File: rtl/sseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : sseg_scan_driver
// Brief   : Time-multiplexed N-digit common-anode seven-segment scan driver
//           with frame-aligned double-buffered loads.
// Revision: 1.0 - initial release
// ============================================================================
module sseg_scan_driver #(
    parameter int N_DIGITS      = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic                  lz_blank,
    input  logic                  load,
    output logic                  upd,
    output logic [6:0]            sseg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an
);

    localparam int c_CNT_W = $clog2(REFRESH_DIV);
    localparam int c_DIG_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int c_VAL_W = 4 * N_DIGITS;
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [c_DIG_W-1:0]  c_DIG_LAST = c_DIG_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] c_AN_OFF   = {N_DIGITS{AN_ACTIVE_LOW}};

    logic [c_CNT_W-1:0]  r_slot_q,       w_slot_d;
    logic [c_DIG_W-1:0]  r_digit_q,      w_digit_d;
    logic [c_VAL_W-1:0]  r_disp_val_q,   w_disp_val_d;
    logic [N_DIGITS-1:0] r_disp_dp_q,    w_disp_dp_d;
    logic [N_DIGITS-1:0] r_disp_blank_q, w_disp_blank_d;
    logic [c_VAL_W-1:0]  r_pend_val_q,   w_pend_val_d;
    logic [N_DIGITS-1:0] r_pend_dp_q,    w_pend_dp_d;
    logic [N_DIGITS-1:0] r_pend_blank_q, w_pend_blank_d;
    logic                r_pend_vld_q,   w_pend_vld_d;
    logic                r_upd_q,        w_upd_d;
    logic [6:0]          r_sseg_q,       w_sseg_d;
    logic                r_dp_q,         w_dp_d;
    logic [N_DIGITS-1:0] r_an_q,         w_an_d;

    logic                w_slot_end;
    logic                w_boundary;
    logic [N_DIGITS-1:0] w_upper_zero;
    logic                w_zero_run;
    logic [3:0]          w_nib;
    logic                w_dp_bit;
    logic                w_blanked;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    always_comb begin
        w_slot_end = (r_slot_q == c_CNT_LAST);
        w_boundary = w_slot_end && (r_digit_q == c_DIG_LAST);

        w_slot_d  = w_slot_end ? '0 : r_slot_q + c_CNT_W'(1);
        w_digit_d = r_digit_q;
        if (w_slot_end) begin
            w_digit_d = (r_digit_q == c_DIG_LAST) ? '0 : r_digit_q + c_DIG_W'(1);
        end

        w_disp_val_d   = r_disp_val_q;
        w_disp_dp_d    = r_disp_dp_q;
        w_disp_blank_d = r_disp_blank_q;
        w_pend_val_d   = r_pend_val_q;
        w_pend_dp_d    = r_pend_dp_q;
        w_pend_blank_d = r_pend_blank_q;
        w_pend_vld_d   = r_pend_vld_q;
        w_upd_d        = 1'b0;

        // A load landing on the boundary itself skips the pending stage.
        if (w_boundary && load) begin
            w_disp_val_d   = value;
            w_disp_dp_d    = dp_in;
            w_disp_blank_d = blank_in;
            w_pend_vld_d   = 1'b0;
            w_upd_d        = 1'b1;
        end else if (w_boundary && r_pend_vld_q) begin
            w_disp_val_d   = r_pend_val_q;
            w_disp_dp_d    = r_pend_dp_q;
            w_disp_blank_d = r_pend_blank_q;
            w_pend_vld_d   = 1'b0;
            w_upd_d        = 1'b1;
        end else if (load) begin
            w_pend_val_d   = value;
            w_pend_dp_d    = dp_in;
            w_pend_blank_d = blank_in;
            w_pend_vld_d   = 1'b1;
        end

        w_zero_run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            w_zero_run      = w_zero_run && (w_disp_val_d[4*i +: 4] == 4'h0);
            w_upper_zero[i] = w_zero_run;
        end

        // Outputs are computed from next state so they line up with the counters.
        w_nib     = 4'h0;
        w_dp_bit  = 1'b0;
        w_blanked = 1'b0;
        w_an_d    = c_AN_OFF;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (w_digit_d == c_DIG_W'(i)) begin
                w_nib     = w_disp_val_d[4*i +: 4];
                w_dp_bit  = w_disp_dp_d[i];
                w_blanked = w_disp_blank_d[i] || (lz_blank && w_upper_zero[i] && (i != 0));
                if (w_slot_d != '0) begin
                    w_an_d[i] = ~AN_ACTIVE_LOW;
                end
            end
        end

        w_sseg_d = w_blanked ? 7'b1111111 : f_decode(w_nib);
        w_dp_d   = w_blanked ? 1'b1 : ~w_dp_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_q       <= '0;
            r_digit_q      <= '0;
            r_disp_val_q   <= '0;
            r_disp_dp_q    <= '0;
            r_disp_blank_q <= '0;
            r_pend_val_q   <= '0;
            r_pend_dp_q    <= '0;
            r_pend_blank_q <= '0;
            r_pend_vld_q   <= 1'b0;
            r_upd_q        <= 1'b0;
            r_sseg_q       <= 7'b1111111;
            r_dp_q         <= 1'b1;
            r_an_q         <= c_AN_OFF;
        end else begin
            r_slot_q       <= w_slot_d;
            r_digit_q      <= w_digit_d;
            r_disp_val_q   <= w_disp_val_d;
            r_disp_dp_q    <= w_disp_dp_d;
            r_disp_blank_q <= w_disp_blank_d;
            r_pend_val_q   <= w_pend_val_d;
            r_pend_dp_q    <= w_pend_dp_d;
            r_pend_blank_q <= w_pend_blank_d;
            r_pend_vld_q   <= w_pend_vld_d;
            r_upd_q        <= w_upd_d;
            r_sseg_q       <= w_sseg_d;
            r_dp_q         <= w_dp_d;
            r_an_q         <= w_an_d;
        end
    end

    assign upd  = r_upd_q;
    assign sseg = r_sseg_q;
    assign dp   = r_dp_q;
    assign an   = r_an_q;

endmodule
`default_nettype wire

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode seven-segment display.
- Stores a packed hex word, per-digit decimal points and per-digit blank masks, then scans one digit per refresh slot.
- Display contents change only at frame boundaries, so a load never causes tearing.
- Sits between the datapath and the board display pins; replaces per-digit combinational decoders.

Parameters:
- N_DIGITS, 4, number of digits scanned (legal 1..8).
- REFRESH_DIV, 50000, clock cycles per digit slot (legal >= 2).
- AN_ACTIVE_LOW, 1, 1: an bit = 0 enables a digit; 0: an bit = 1 enables.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- value  in  4*N_DIGITS  hex nibbles; digit i = value[4i+3:4i]; digit 0 = rightmost
- dp_in  in  N_DIGITS  decimal point request per digit, 1 = lit
- blank_in  in  N_DIGITS  force-blank per digit, 1 = dark
- lz_blank  in  1  leading-zero suppression enable, sampled live
- load  in  1  one-cycle strobe; captures value/dp_in/blank_in
- upd  out  1  one-cycle pulse when a capture reaches the display register
- sseg  out  7  segments a..g = bit6..bit0, active-low (0 = lit)
- dp  out  1  decimal point, active-low
- an  out  N_DIGITS  digit enables, polarity per AN_ACTIVE_LOW

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - slot counter = 0, digit index = 0.
  - Display register and pending register cleared (value 0, dp 0, blank 0); pending valid = 0.
  - upd = 0, sseg = 7'b1111111, dp = 1, an = all inactive.
- Scan timing:
  - Slot counter counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it wraps to 0 and digit index increments, wrapping N_DIGITS-1 -> 0.
  - The first slot (digit 0) starts on the first cycle after rst deasserts.
- Dead time:
  - In slot cycle 0, an is all inactive.
  - In cycles 1..REFRESH_DIV-1, only the an bit of the current digit is active.
  - sseg and dp hold the current digit's pattern for the whole slot.
  - All outputs are registered.
- Decode, nibble -> sseg:
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110
  - 4:1001100, 5:0100100, 6:0100000, 7:0001111
  - 8:0000000, 9:0000100, A:0001000, b:1100000
  - C:0110001, d:1000010, E:0110000, F:0111000
- Blanking (a blanked digit drives sseg = 1111111 and dp = 1; its an still pulses, so timing is unchanged). Digit i is blanked if either:
  - blank_in captured bit i = 1, or
  - lz_blank = 1 and nibbles i..N_DIGITS-1 are all zero and i != 0. Digit 0 is never zero-suppressed.
- dp: dp = ~dp captured bit i unless the digit is blanked.
- Load / frame update:
  - load copies value, dp_in and blank_in into pending and sets pending valid.
  - A second load before transfer overwrites pending (last wins).
  - Frame boundary = the cycle the digit index wraps to 0.
  - At the frame boundary with pending valid: display register <= pending, pending valid cleared, upd = 1 for that one cycle.
  - load on the boundary cycle itself: the new data bypasses straight into the display register at that boundary, upd = 1, pending valid left 0.
  - N_DIGITS = 1: every slot end is a frame boundary.
- Reset mid-scan returns to the reset state on the next edge and discards pending data.

Test Plan (N_DIGITS=4, REFRESH_DIV=4, AN_ACTIVE_LOW=1):
- Reset release, no load -> an sequence per slot: 1111, 1110, 1110, 1110, then 1111, 1101, ... Digits 3..0 all show sseg = 0000001; upd never pulses.
- load value=16'h1A2F mid-frame -> display unchanged until digit index wraps to 0. upd pulses once. Digit 0 = 0111000, digit 1 = 0010010, digit 2 = 0001000, digit 3 = 1001111.
- lz_blank=1, value=16'h0005 -> digits 3, 2, 1 give sseg = 1111111 with an still pulsing; digit 0 = 0100100. Same with value=16'h0000: digit 0 = 0000001.
- dp_in=4'b0100, blank_in=4'b1000, value=16'h8888 -> digit 2 dp = 0 (others dp = 1); digit 3 sseg = 1111111; digits 0..2 = 0000000.
- Two loads (16'h1111 then 16'h2222) in one frame -> only 16'h2222 is displayed; exactly one upd. A load on the boundary cycle is applied at that same boundary.
- Assert rst for 1 cycle mid-slot with pending valid -> next cycle all outputs at reset values; pending dropped, no upd at the next boundary.
